// File: rtl/inter_read_rr_if.sv
// Bus bundle for the inter_read_rr read crossbar: master-side request/response
// lines and slave-side request/data lines. 'slave' is the crossbar's view.
interface inter_read_rr_if #(
    parameter int DATA_WIDTH          = 32,
    parameter int ROMASTER_ADDR_WIDTH = 11,
    parameter int SLAVE_ADDR_WIDTH    = 10,
    parameter int ROMASTERS           = 2,
    parameter int ROSLAVES            = 2
);
    logic [ROMASTERS-1:0]                     master_data_req_i;
    logic [ROMASTERS*ROMASTER_ADDR_WIDTH-1:0] master_data_addr_i;
    logic [ROMASTERS-1:0]                     master_data_gnt_o;
    logic [ROMASTERS-1:0]                     master_data_rvalid_o;
    logic [ROMASTERS*DATA_WIDTH-1:0]          master_data_rdata_o;
    logic [ROMASTERS-1:0]                     master_data_err_o;
    logic [ROSLAVES-1:0]                      slave_data_req_o;
    logic [ROSLAVES*SLAVE_ADDR_WIDTH-1:0]     slave_data_addr_o;
    logic [ROSLAVES*DATA_WIDTH-1:0]           slave_data_rdata_i;
    logic [ROSLAVES-1:0]                      slave_data_gnt_i;

    modport slave (
        input  master_data_req_i, master_data_addr_i, slave_data_rdata_i, slave_data_gnt_i,
        output master_data_gnt_o, master_data_rvalid_o, master_data_rdata_o, master_data_err_o,
        output slave_data_req_o, slave_data_addr_o
    );

    // Environment side: the fetch masters together with the memory banks.
    modport master (
        output master_data_req_i, master_data_addr_i, slave_data_rdata_i, slave_data_gnt_i,
        input  master_data_gnt_o, master_data_rvalid_o, master_data_rdata_o, master_data_err_o,
        input  slave_data_req_o, slave_data_addr_o
    );
endinterface

// File: rtl/inter_read_rr.sv
// Read-only crossbar: per-slave round-robin arbitration, fixed-latency response
// return to the issuing master, and decode-error responses for bad selects.
module inter_read_rr #(
    parameter int DATA_WIDTH          = 32,
    parameter int ROMASTER_ADDR_WIDTH = 11,
    parameter int SLAVE_ADDR_WIDTH    = 10,
    parameter int ROMASTERS           = 2,
    parameter int ROSLAVES            = 2,
    parameter int RD_LATENCY          = 1
) (
    input  logic          clk,
    input  logic          reset,
    inter_read_rr_if.slave bus
);
    localparam int SEL_W = (ROSLAVES > 1) ? $clog2(ROSLAVES) : 1;
    localparam int ID_W  = (ROMASTERS > 1) ? $clog2(ROMASTERS) : 1;
    localparam logic [SEL_W:0] NUM_SLAVES = (SEL_W+1)'(ROSLAVES);

    logic                        req_m    [ROMASTERS];
    logic                        bad_m    [ROMASTERS];
    logic [SEL_W-1:0]            sel_m    [ROMASTERS];
    logic [SLAVE_ADDR_WIDTH-1:0] addr_m   [ROMASTERS];
    logic                        accept_s [ROSLAVES];
    logic [ID_W-1:0]             win_s    [ROSLAVES];
    logic                        resp_v_s [ROSLAVES];
    logic [ID_W-1:0]             resp_id_s[ROSLAVES];

    genvar gi;

    // Requests are masked during reset so every combinational output reads 0.
    for (gi = 0; gi < ROMASTERS; gi++) begin : g_decode
        assign req_m[gi]  = bus.master_data_req_i[gi] & ~reset;
        assign sel_m[gi]  = bus.master_data_addr_i[gi*ROMASTER_ADDR_WIDTH + SLAVE_ADDR_WIDTH +: SEL_W];
        assign addr_m[gi] = bus.master_data_addr_i[gi*ROMASTER_ADDR_WIDTH +: SLAVE_ADDR_WIDTH];
        assign bad_m[gi]  = req_m[gi] & ({1'b0, sel_m[gi]} >= NUM_SLAVES);
    end

    for (gi = 0; gi < ROSLAVES; gi++) begin : g_slave
        localparam logic [SEL_W-1:0] SID = SEL_W'(gi);

        logic [ID_W-1:0]       ptr_reg;
        logic [ID_W-1:0]       win;
        logic [ID_W-1:0]       idx;
        logic                  found;
        logic [RD_LATENCY-1:0] pipe_v_reg;
        logic [ID_W-1:0]       pipe_id_reg [RD_LATENCY];

        // Scan masters starting just after the last winner, wrapping around.
        always_comb begin
            found = 1'b0;
            win   = '0;
            idx   = '0;
            for (int k = 1; k <= ROMASTERS; k++) begin
                idx = ID_W'((int'(ptr_reg) + k) % ROMASTERS);
                if (!found && req_m[idx] && (sel_m[idx] == SID)) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
        end

        assign accept_s[gi] = found & bus.slave_data_gnt_i[gi];
        assign win_s[gi]    = win;
        assign bus.slave_data_req_o[gi] = found;
        assign bus.slave_data_addr_o[gi*SLAVE_ADDR_WIDTH +: SLAVE_ADDR_WIDTH] =
            found ? addr_m[win] : '0;

        // Pointer moves only on a completed handshake; a stalled slave re-arbitrates.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                ptr_reg    <= ID_W'(ROMASTERS - 1);
                pipe_v_reg <= '0;
                for (int i = 0; i < RD_LATENCY; i++) begin
                    pipe_id_reg[i] <= '0;
                end
            end else begin
                if (accept_s[gi]) begin
                    ptr_reg <= win;
                end
                pipe_v_reg[0]  <= accept_s[gi];
                pipe_id_reg[0] <= win;
                for (int i = 1; i < RD_LATENCY; i++) begin
                    pipe_v_reg[i]  <= pipe_v_reg[i-1];
                    pipe_id_reg[i] <= pipe_id_reg[i-1];
                end
            end
        end

        assign resp_v_s[gi]  = pipe_v_reg[RD_LATENCY-1];
        assign resp_id_s[gi] = pipe_id_reg[RD_LATENCY-1];
    end

    for (gi = 0; gi < ROMASTERS; gi++) begin : g_master
        logic [RD_LATENCY-1:0] err_pipe_reg;
        logic                  gnt;
        logic                  rvalid;
        logic                  err;
        logic [DATA_WIDTH-1:0] rdata;

        // Bad selects bypass the slaves but take the same latency as real reads.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                err_pipe_reg <= '0;
            end else begin
                err_pipe_reg[0] <= bad_m[gi];
                for (int i = 1; i < RD_LATENCY; i++) begin
                    err_pipe_reg[i] <= err_pipe_reg[i-1];
                end
            end
        end

        always_comb begin
            gnt    = bad_m[gi];
            rvalid = err_pipe_reg[RD_LATENCY-1];
            err    = err_pipe_reg[RD_LATENCY-1];
            rdata  = '0;
            for (int s = 0; s < ROSLAVES; s++) begin
                if (accept_s[s] && (win_s[s] == ID_W'(gi))) begin
                    gnt = 1'b1;
                end
                if (resp_v_s[s] && (resp_id_s[s] == ID_W'(gi))) begin
                    rvalid = 1'b1;
                    rdata  = bus.slave_data_rdata_i[s*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end

        assign bus.master_data_gnt_o[gi]    = gnt;
        assign bus.master_data_rvalid_o[gi] = rvalid;
        assign bus.master_data_err_o[gi]    = err;
        assign bus.master_data_rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = rdata;
    end
endmodule

// File: tb/tb_inter_read_rr.sv
// Bench for inter_read_rr (3 masters, 3 slaves, latency 2): directed scenarios
// followed by randomized traffic against a cycle-calendar reference model.
module tb_inter_read_rr;
    localparam int DW  = 32;
    localparam int AW  = 12;
    localparam int SAW = 10;
    localparam int NM  = 3;
    localparam int NS  = 3;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    inter_read_rr_if #(.DATA_WIDTH(DW), .ROMASTER_ADDR_WIDTH(AW), .SLAVE_ADDR_WIDTH(SAW),
                       .ROMASTERS(NM), .ROSLAVES(NS)) bus ();

    inter_read_rr #(.DATA_WIDTH(DW), .ROMASTER_ADDR_WIDTH(AW), .SLAVE_ADDR_WIDTH(SAW),
                    .ROMASTERS(NM), .ROSLAVES(NS), .RD_LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] maddr  [NM];
    logic [NM-1:0] mreq;
    logic [DW-1:0] srdata [NS];
    logic [NS-1:0] sgnt;

    assign bus.master_data_req_i = mreq;
    assign bus.slave_data_gnt_i  = sgnt;
    for (genvar gi = 0; gi < NM; gi++) begin : g_mdrv
        assign bus.master_data_addr_i[gi*AW +: AW] = maddr[gi];
    end
    for (genvar gi = 0; gi < NS; gi++) begin : g_sdrv
        assign bus.slave_data_rdata_i[gi*DW +: DW] = srdata[gi];
    end

    function automatic logic [DW-1:0] rdata_of(input int m);
        return bus.master_data_rdata_o[m*DW +: DW];
    endfunction

    function automatic logic [SAW-1:0] saddr_of(input int s);
        return bus.slave_data_addr_o[s*SAW +: SAW];
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        mreq = '0;
        sgnt = '1;
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mreq = 3'b011; maddr[0] = 12'h005; maddr[1] = 12'h801; sgnt = '1;
        @(negedge clk);
        checks++; if (bus.master_data_gnt_o !== 3'b000) begin errors++; $display("FAIL reset_gnt got=%b exp=000", bus.master_data_gnt_o); end
        checks++; if (bus.slave_data_req_o !== 3'b000) begin errors++; $display("FAIL reset_sreq got=%b exp=000", bus.slave_data_req_o); end
        checks++; if (bus.slave_data_addr_o !== '0) begin errors++; $display("FAIL reset_saddr got=%h exp=0", bus.slave_data_addr_o); end
        checks++; if (bus.master_data_rvalid_o !== 3'b000 || bus.master_data_err_o !== 3'b000) begin
            errors++; $display("FAIL reset_resp rvalid=%b err=%b exp=000/000", bus.master_data_rvalid_o, bus.master_data_err_o); end
        checks++; if (bus.master_data_rdata_o !== '0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.master_data_rdata_o); end
        next_cycle();
        reset = 1'b0;
        idle_cycles(2);
        $display("test_reset done");
    endtask

    task automatic test_single_read();
        mreq = 3'b001; maddr[0] = 12'h005; sgnt = '1; srdata[0] = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (bus.master_data_gnt_o !== 3'b001) begin errors++; $display("FAIL single_gnt got=%b exp=001", bus.master_data_gnt_o); end
        checks++; if (bus.slave_data_req_o !== 3'b001) begin errors++; $display("FAIL single_sreq got=%b exp=001", bus.slave_data_req_o); end
        checks++; if (saddr_of(0) !== 10'h005) begin errors++; $display("FAIL single_saddr got=%h exp=005", saddr_of(0)); end
        next_cycle(); mreq = '0;
        @(negedge clk);
        checks++; if (bus.master_data_rvalid_o !== 3'b000) begin errors++; $display("FAIL single_early got=%b exp=000", bus.master_data_rvalid_o); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.master_data_rvalid_o !== 3'b001) begin errors++; $display("FAIL single_rvalid got=%b exp=001", bus.master_data_rvalid_o); end
        checks++; if (rdata_of(0) !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata got=%h exp=deadbeef", rdata_of(0)); end
        checks++; if (bus.master_data_err_o !== 3'b000) begin errors++; $display("FAIL single_err got=%b exp=000", bus.master_data_err_o); end
        idle_cycles(3);
        $display("txn single_read m0 addr=005 data=deadbeef");
    endtask

    task automatic test_round_robin();
        logic [NM-1:0] exp_g;
        logic [NM-1:0] exp_r;
        mreq = 3'b111; sgnt = '1;
        for (int m = 0; m < NM; m++) maddr[m] = 12'h410 + 12'(m);
        for (int c = 0; c < 8; c++) begin
            srdata[1] = 32'h1000_0000 + 32'(c);
            exp_g = 3'(1 << (c % 3));
            @(negedge clk);
            checks++; if (bus.master_data_gnt_o !== exp_g) begin errors++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, bus.master_data_gnt_o, exp_g); end
            checks++; if (saddr_of(1) !== 10'h010 + 10'(c % 3)) begin errors++; $display("FAIL rr_saddr c=%0d got=%h exp=%h", c, saddr_of(1), 10'h010 + 10'(c % 3)); end
            if (c >= LAT) begin
                exp_r = 3'(1 << ((c - LAT) % 3));
                checks++; if (bus.master_data_rvalid_o !== exp_r) begin errors++; $display("FAIL rr_rvalid c=%0d got=%b exp=%b", c, bus.master_data_rvalid_o, exp_r); end
                checks++; if (rdata_of((c - LAT) % 3) !== srdata[1]) begin errors++; $display("FAIL rr_rdata c=%0d got=%h exp=%h", c, rdata_of((c - LAT) % 3), srdata[1]); end
            end
            $display("txn round_robin c=%0d gnt=%b", c, bus.master_data_gnt_o);
            next_cycle();
        end
        idle_cycles(3);
    endtask

    task automatic test_stall();
        mreq = 3'b011; maddr[0] = 12'h011; maddr[1] = 12'h023; srdata[0] = 32'hCAFE0000;
        for (int c = 0; c < 3; c++) begin
            sgnt = 3'b110;
            @(negedge clk);
            checks++; if (bus.master_data_gnt_o !== 3'b000) begin errors++; $display("FAIL stall_gnt c=%0d got=%b exp=000", c, bus.master_data_gnt_o); end
            checks++; if (bus.slave_data_req_o[0] !== 1'b1 || saddr_of(0) !== 10'h023) begin
                errors++; $display("FAIL stall_sreq c=%0d req=%b addr=%h exp=1/023", c, bus.slave_data_req_o[0], saddr_of(0)); end
            next_cycle();
        end
        sgnt = '1;
        @(negedge clk);
        checks++; if (bus.master_data_gnt_o !== 3'b010) begin errors++; $display("FAIL stall_release got=%b exp=010", bus.master_data_gnt_o); end
        next_cycle(); mreq = 3'b001;
        @(negedge clk);
        checks++; if (bus.master_data_gnt_o !== 3'b001) begin errors++; $display("FAIL stall_next got=%b exp=001", bus.master_data_gnt_o); end
        next_cycle(); mreq = '0;
        @(negedge clk);
        checks++; if (bus.master_data_rvalid_o !== 3'b010 || rdata_of(1) !== 32'hCAFE0000) begin
            errors++; $display("FAIL stall_resp1 rvalid=%b data=%h exp=010/cafe0000", bus.master_data_rvalid_o, rdata_of(1)); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.master_data_rvalid_o !== 3'b001 || rdata_of(0) !== 32'hCAFE0000) begin
            errors++; $display("FAIL stall_resp0 rvalid=%b data=%h exp=001/cafe0000", bus.master_data_rvalid_o, rdata_of(0)); end
        idle_cycles(3);
        $display("txn stall m1 then m0 on slave0");
    endtask

    task automatic test_bad_select();
        mreq = 3'b011; maddr[0] = 12'hC07; maddr[1] = 12'h8AB; sgnt = '1; srdata[2] = 32'h22222222;
        @(negedge clk);
        checks++; if (bus.master_data_gnt_o !== 3'b011) begin errors++; $display("FAIL bad_gnt got=%b exp=011", bus.master_data_gnt_o); end
        checks++; if (bus.slave_data_req_o !== 3'b100 || saddr_of(2) !== 10'h0AB) begin
            errors++; $display("FAIL bad_sreq req=%b addr=%h exp=100/0ab", bus.slave_data_req_o, saddr_of(2)); end
        next_cycle(); mreq = '0;
        @(negedge clk);
        checks++; if (bus.master_data_rvalid_o !== 3'b000) begin errors++; $display("FAIL bad_early got=%b exp=000", bus.master_data_rvalid_o); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.master_data_rvalid_o !== 3'b011 || bus.master_data_err_o !== 3'b001) begin
            errors++; $display("FAIL bad_resp rvalid=%b err=%b exp=011/001", bus.master_data_rvalid_o, bus.master_data_err_o); end
        checks++; if (rdata_of(0) !== 32'h0 || rdata_of(1) !== 32'h22222222) begin
            errors++; $display("FAIL bad_rdata d0=%h d1=%h exp=0/22222222", rdata_of(0), rdata_of(1)); end
        idle_cycles(3);
        $display("txn bad_select m0 sel=3 err, m1 slave2");
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_d [3];
        exp_d[0] = 32'hA0A0A0A0; exp_d[1] = 32'hB1B1B1B1; exp_d[2] = 32'hC2C2C2C2;
        for (int s = 0; s < NS; s++) srdata[s] = exp_d[s];
        sgnt = '1;
        for (int c = 0; c < 5; c++) begin
            mreq = (c < 3) ? 3'b001 : 3'b000;
            maddr[0] = {2'(c), 10'h030 + 10'(c)};
            @(negedge clk);
            if (c < 3) begin
                checks++; if (bus.master_data_gnt_o !== 3'b001) begin errors++; $display("FAIL b2b_gnt c=%0d got=%b exp=001", c, bus.master_data_gnt_o); end
            end
            if (c < LAT) begin
                checks++; if (bus.master_data_rvalid_o !== 3'b000) begin errors++; $display("FAIL b2b_early c=%0d got=%b exp=000", c, bus.master_data_rvalid_o); end
            end else begin
                checks++; if (bus.master_data_rvalid_o !== 3'b001 || rdata_of(0) !== exp_d[c-LAT]) begin
                    errors++; $display("FAIL b2b_resp c=%0d rvalid=%b data=%h exp=001/%h", c, bus.master_data_rvalid_o, rdata_of(0), exp_d[c-LAT]); end
            end
            next_cycle();
        end
        idle_cycles(3);
        $display("txn back_to_back m0 slaves 0,1,2");
    endtask

    task automatic test_reset_inflight();
        mreq = 3'b001; maddr[0] = 12'h044; sgnt = '1; srdata[0] = 32'h55AA55AA;
        @(negedge clk);
        checks++; if (bus.master_data_gnt_o !== 3'b001) begin errors++; $display("FAIL rst_pre_gnt got=%b exp=001", bus.master_data_gnt_o); end
        next_cycle(); mreq = '0; reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.master_data_rvalid_o !== 3'b000) begin errors++; $display("FAIL rst_drop0 got=%b exp=000", bus.master_data_rvalid_o); end
        next_cycle(); reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (bus.master_data_rvalid_o !== 3'b000) begin errors++; $display("FAIL rst_drop c=%0d got=%b exp=000", c, bus.master_data_rvalid_o); end
            next_cycle();
        end
        mreq = 3'b011; maddr[0] = 12'h001; maddr[1] = 12'h002;
        @(negedge clk);
        checks++; if (bus.master_data_gnt_o !== 3'b001) begin errors++; $display("FAIL rst_prio got=%b exp=001", bus.master_data_gnt_o); end
        next_cycle(); mreq = 3'b010;
        @(negedge clk);
        checks++; if (bus.master_data_gnt_o !== 3'b010) begin errors++; $display("FAIL rst_prio2 got=%b exp=010", bus.master_data_gnt_o); end
        idle_cycles(3);
        $display("txn reset_inflight dropped, m0 first after reset");
    endtask

    // Reference model: arbitration from rotating priority, responses kept in a
    // calendar indexed by the cycle on which they are due.
    task automatic test_random(input int ncycles);
        int            ptr [NS];
        int            win [NS];
        bit            pend_v   [8][NM];
        bit            pend_err [8][NM];
        int            pend_sl  [8][NM];
        logic [NM-1:0] exp_gnt, exp_rv, exp_err;
        logic [NS-1:0] exp_sreq;
        logic [SAW-1:0] exp_saddr [NS];
        logic [DW-1:0] exp_rdata [NM];
        int            slot, due, m, sel;

        reset = 1'b1; mreq = '0; sgnt = '1;
        next_cycle(); next_cycle();
        reset = 1'b0;
        for (int s = 0; s < NS; s++) ptr[s] = NM - 1;
        for (int t = 0; t < 8; t++) for (int i = 0; i < NM; i++) pend_v[t][i] = 1'b0;

        for (int cyc = 0; cyc < ncycles; cyc++) begin
            for (int i = 0; i < NM; i++) begin
                if (!mreq[i] && $urandom_range(0, 2) != 0) begin
                    mreq[i] = 1'b1;
                    maddr[i][AW-1:SAW] = 2'($urandom_range(0, 3));
                    maddr[i][SAW-1:0]  = SAW'($urandom);
                end
            end
            for (int s = 0; s < NS; s++) begin
                sgnt[s]   = ($urandom_range(0, 3) != 0);
                srdata[s] = $urandom;
            end
            @(negedge clk);

            exp_gnt = '0; exp_sreq = '0;
            for (int s = 0; s < NS; s++) begin
                win[s] = -1; exp_saddr[s] = '0;
                for (int k = 1; k <= NM; k++) begin
                    m = (ptr[s] + k) % NM;
                    if (win[s] < 0 && mreq[m] && int'(maddr[m][AW-1:SAW]) == s) win[s] = m;
                end
                if (win[s] >= 0) begin
                    exp_sreq[s]  = 1'b1;
                    exp_saddr[s] = maddr[win[s]][SAW-1:0];
                    if (sgnt[s]) exp_gnt[win[s]] = 1'b1;
                end
            end
            for (int i = 0; i < NM; i++)
                if (mreq[i] && int'(maddr[i][AW-1:SAW]) >= NS) exp_gnt[i] = 1'b1;

            slot = cyc % 8;
            for (int i = 0; i < NM; i++) begin
                exp_rv[i]    = pend_v[slot][i];
                exp_err[i]   = pend_v[slot][i] && pend_err[slot][i];
                exp_rdata[i] = (pend_v[slot][i] && !pend_err[slot][i]) ? srdata[pend_sl[slot][i]] : '0;
            end

            checks++; if (bus.master_data_gnt_o !== exp_gnt) begin errors++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, bus.master_data_gnt_o, exp_gnt); end
            checks++; if (bus.slave_data_req_o !== exp_sreq) begin errors++; $display("FAIL rnd_sreq cyc=%0d got=%b exp=%b", cyc, bus.slave_data_req_o, exp_sreq); end
            checks++; if (bus.master_data_rvalid_o !== exp_rv) begin errors++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, bus.master_data_rvalid_o, exp_rv); end
            checks++; if (bus.master_data_err_o !== exp_err) begin errors++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, bus.master_data_err_o, exp_err); end
            for (int s = 0; s < NS; s++) begin
                checks++; if (saddr_of(s) !== exp_saddr[s]) begin errors++; $display("FAIL rnd_saddr cyc=%0d s=%0d got=%h exp=%h", cyc, s, saddr_of(s), exp_saddr[s]); end
            end
            for (int i = 0; i < NM; i++) begin
                checks++; if (rdata_of(i) !== exp_rdata[i]) begin errors++; $display("FAIL rnd_rdata cyc=%0d m=%0d got=%h exp=%h", cyc, i, rdata_of(i), exp_rdata[i]); end
            end

            for (int i = 0; i < NM; i++) pend_v[slot][i] = 1'b0;
            due = (cyc + LAT) % 8;
            for (int i = 0; i < NM; i++) begin
                if (exp_gnt[i]) begin
                    sel = int'(maddr[i][AW-1:SAW]);
                    pend_v[due][i]   = 1'b1;
                    pend_err[due][i] = (sel >= NS);
                    pend_sl[due][i]  = sel;
                    $display("txn rnd cyc=%0d m=%0d addr=%h", cyc, i, maddr[i]);
                end
            end
            for (int s = 0; s < NS; s++) if (win[s] >= 0 && sgnt[s]) ptr[s] = win[s];

            next_cycle();
            for (int i = 0; i < NM; i++) if (exp_gnt[i]) mreq[i] = 1'b0;
        end
        idle_cycles(3);
    endtask

    initial begin
        reset = 1'b1;
        mreq = '0;
        sgnt = '1;
        for (int i = 0; i < NM; i++) maddr[i] = '0;
        for (int s = 0; s < NS; s++) srdata[s] = '0;
        next_cycle();
        test_reset();
        test_single_read();
        test_round_robin();
        test_stall();
        test_bad_select();
        test_back_to_back();
        test_reset_inflight();
        test_random(300);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/inter_read_rr.md
Name: inter_read_rr

Overview:
Parametrised next-generation read crossbar connecting ROMASTERS read-only masters to ROSLAVES memory slaves, sitting between core/fabric fetch ports and banked memory.
- Adds fair round-robin arbitration per slave and handshake-qualified pointer advance.
- Adds a fixed-latency registered response path that returns rdata/rvalid to the issuing master RD_LATENCY cycles after the grant.
- Adds a decode-error response for out-of-range slave selects.
- Supports multiple outstanding reads per master.

Parameters:
DATA_WIDTH, 32, read data width
ROMASTER_ADDR_WIDTH, 11, master address width
SLAVE_ADDR_WIDTH, 10, slave address width (low bits forwarded to the slave)
ROMASTERS, 2, number of masters (1..8)
ROSLAVES, 2, number of slaves (1..8, need not be a power of two)
RD_LATENCY, 1, cycles from accepted request to slave rdata valid (1..4)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous active-high reset
master_data_req_i  in  ROMASTERS  per-master read request
master_data_addr_i  in  ROMASTERS*ROMASTER_ADDR_WIDTH  packed master addresses
master_data_gnt_o  out  ROMASTERS  request accepted this cycle
master_data_rvalid_o  out  ROMASTERS  one-cycle response pulse
master_data_rdata_o  out  ROMASTERS*DATA_WIDTH  response data
master_data_err_o  out  ROMASTERS  decode error, qualified by rvalid
slave_data_req_o  out  ROSLAVES  per-slave request
slave_data_addr_o  out  ROSLAVES*SLAVE_ADDR_WIDTH  per-slave address
slave_data_rdata_i  in  ROSLAVES*DATA_WIDTH  slave read data, valid RD_LATENCY cycles after accept
slave_data_gnt_i  in  ROSLAVES  slave accepts request

Behaviour:
- Slave select: sel_m = addr_m[SLAVE_ADDR_WIDTH +: SEL_W], where SEL_W = max(1, clog2(ROSLAVES)).
- Bad select: if sel_m >= ROSLAVES, the request is a bad select.
- Arbitration:
  - Per slave s, the candidates are masters with req=1 and sel=s.
  - Grant is combinational, same cycle. Priority starts at ptr_s+1 and wraps modulo ROMASTERS.
  - At most one master is granted per slave.
  - Each master targets one slave, so it holds at most one grant.
- Slave drive:
  - slave_data_req_o[s] = 1 if any candidate exists.
  - slave_data_addr_o[s] = low SLAVE_ADDR_WIDTH bits of the granted master's address; 0 when idle.
- Accept: accept_s = slave_data_req_o[s] & slave_data_gnt_i[s]. master_data_gnt_o[m] = 1 in the same cycle for the master that won slave s.
- Pointer update: ptr_s <= winner index on accept_s only. If the slave stalls (gnt=0), the pointer holds and arbitration re-evaluates next cycle. A newly arriving higher-priority master may therefore win the stalled slave.
- Master protocol: a master holds req and addr stable until gnt. The crossbar does not check this.
- Bad-select handling: master_data_gnt_o = 1 in the same cycle with no slave request. An error token then enters a per-master RD_LATENCY-deep pipeline.
- Response pipeline (per slave):
  - A RD_LATENCY-stage shift register of {valid, master_id} is loaded on accept_s, and shifts every cycle with no stall.
  - When the output stage is valid, the crossbar drives master_data_rvalid_o[id]=1 and master_data_rdata_o[id] = slave_data_rdata_i[s] combinationally in that cycle (RD_LATENCY cycles after gnt).
  - master_data_err_o = 0 for these responses.
- Error response: the error pipeline output drives rvalid=1, rdata=0, err=1.
- Response ordering:
  - All paths have equal latency, so responses return in issue order per master.
  - A master has at most one response per cycle, so no collision is possible.
- rvalid is a single-cycle pulse with no backpressure: a master must accept it.
- Outputs when idle: rdata=0, rvalid=0, err=0.
- Reset (async, any time):
  - ptr_s = ROMASTERS-1, so master 0 has priority after reset.
  - All pipeline valids clear. In-flight responses are dropped, with no rvalid afterward.
  - All outputs read 0 while reset is high.
- Simultaneous events: an accept and a response for the same master in the same cycle are independent and both occur.

Test Plan:
1. ROMASTERS=2, ROSLAVES=2, RD_LATENCY=1. M0 reads addr 0x005 (slave 0) with slave gnt=1 → gnt0 in cycle t, slave_addr_o[0]=0x005, rvalid0 at t+1 with rdata = slave0 rdata (0xDEADBEEF), err0=0.
2. M0 and M1 both continuously request slave 1 (0x4xx) with gnt tied 1 → grants alternate M0, M1, M0, M1…; each master's rvalid follows its gnt by 1 cycle.
3. Slave 0 gnt held 0 for 3 cycles while M1 requests → slave_req_o[0]=1, gnt1=0, ptr unchanged. gnt goes 1 on the 4th cycle → gnt1 that cycle, rvalid1 next cycle.
4. ROSLAVES=3, M0 address select=3 → gnt0 same cycle, no slave req, rvalid0 after RD_LATENCY with rdata=0, err0=1.
5. RD_LATENCY=3, M0 issues back-to-back reads to slave 0 then slave 1 → rvalid0 at t+3 and t+4, in order, with data from the correct slave.
6. Assert reset one cycle after an accept (RD_LATENCY=2) → no rvalid is produced. After release, simultaneous M0/M1 requests to slave 0 grant M0 first.
